// File: rtl/udma_hyper_trans_sched.sv
// -----------------------------------------------------------------------------
// udma_hyper_trans_sched
//
// Collects transaction descriptors from NB_CH register-interface instances,
// queues them in arrival order and hands them one at a time to the hyperbus
// engine. Requesters are served round-robin; only one transaction is ever in
// flight on the engine side.
//
// Ports
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   req_valid_i         : per-ID request strobe
//   req_cfg_i           : per-ID descriptor, ID i at [i*CFG_W +: CFG_W]
//   req_ready_o         : per-ID accept (one-hot or zero), combinational
//   trans_valid_o       : head descriptor offered to the engine
//   trans_cfg_o         : head descriptor (zero when not offering)
//   trans_id_o          : requester ID of the head descriptor
//   trans_ready_i       : engine accepts the offered descriptor
//   trans_done_i        : engine finished the active transaction (pulse)
//   nb_trans_waiting_o  : number of queued entries (active one excluded)
//   busy_o              : a transaction is being offered or is in flight
// -----------------------------------------------------------------------------
module udma_hyper_trans_sched #(
    parameter  int NB_CH       = 2,
    parameter  int CFG_W       = 64,
    parameter  int MAX_NB_TRAN = 8,
    localparam int IDW         = (NB_CH > 1) ? $clog2(NB_CH) : 1,
    localparam int CW          = $clog2(MAX_NB_TRAN) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NB_CH-1:0]         req_valid_i,
    input  logic [NB_CH*CFG_W-1:0]   req_cfg_i,
    output logic [NB_CH-1:0]         req_ready_o,
    output logic                     trans_valid_o,
    output logic [CFG_W-1:0]         trans_cfg_o,
    output logic [IDW-1:0]           trans_id_o,
    input  logic                     trans_ready_i,
    input  logic                     trans_done_i,
    output logic [MAX_NB_TRAN:0]     nb_trans_waiting_o,
    output logic                     busy_o
);

    localparam int PW = (MAX_NB_TRAN > 1) ? $clog2(MAX_NB_TRAN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACTIVE
    } state_e;

    state_e           state_q;
    logic             trans_valid_q;
    logic [CFG_W-1:0] trans_cfg_q;
    logic [IDW-1:0]   trans_id_q;

    logic [CFG_W-1:0] cfg_mem [MAX_NB_TRAN];
    logic [IDW-1:0]   id_mem  [MAX_NB_TRAN];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;

    logic [NB_CH-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   arb_idx;
    logic [CFG_W-1:0] push_cfg;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_NB_TRAN - 1)) ? '0 : p + PW'(1);
    endfunction

    // Round-robin search starting one past the last granted ID. Grants are
    // only possible while the queue had room at the start of the cycle, so a
    // pop in the same cycle does not open a slot until the next one.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write;
        // a path that leaves one unassigned would infer a latch.
        grant    = '0;
        grant_id = '0;
        arb_idx  = '0;
        push     = 1'b0;
        if (count_q < CW'(MAX_NB_TRAN)) begin
            for (int k = 1; k <= NB_CH; k++) begin
                arb_idx = IDW'((int'(last_grant_q) + k) % NB_CH);
                if (!push && req_valid_i[arb_idx]) begin
                    push            = 1'b1;
                    grant[arb_idx]  = 1'b1;
                    grant_id        = arb_idx;
                end
            end
        end
    end

    assign push_cfg = req_cfg_i[int'(grant_id)*CFG_W +: CFG_W];
    assign pop      = (state_q == ISSUE) && trans_ready_i;

    always_comb begin
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        last_grant_d = push ? grant_id : last_grant_q;
        count_d      = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the values from before the edge.
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= IDW'(NB_CH - 1);
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read once the
    // count says it was written, and the outputs are zeroed outside ISSUE.
    always_ff @(posedge clk_i) begin
        if (push) begin
            cfg_mem[wr_ptr_q] <= push_cfg;
            id_mem[wr_ptr_q]  <= grant_id;
        end
    end

    // Sequencer. The head entry is captured into the output registers on the
    // way into ISSUE; it cannot change until the pop, so it stays stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            trans_valid_q <= 1'b0;
            trans_cfg_q   <= '0;
            trans_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q       <= ISSUE;
                        trans_valid_q <= 1'b1;
                        trans_cfg_q   <= cfg_mem[rd_ptr_q];
                        trans_id_q    <= id_mem[rd_ptr_q];
                    end
                end
                ISSUE: begin
                    if (trans_ready_i) begin
                        state_q       <= ACTIVE;
                        trans_valid_q <= 1'b0;
                        trans_cfg_q   <= '0;
                        trans_id_q    <= '0;
                    end
                end
                ACTIVE: begin
                    if (trans_done_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    trans_valid_q <= 1'b0;
                    trans_cfg_q   <= '0;
                    trans_id_q    <= '0;
                end
            endcase
        end
    end

    // The accept path is combinational, so it is gated while reset is held.
    assign req_ready_o        = rst_ni ? grant : '0;
    assign trans_valid_o      = trans_valid_q;
    assign trans_cfg_o        = trans_cfg_q;
    assign trans_id_o         = trans_id_q;
    assign busy_o             = (state_q != IDLE);
    assign nb_trans_waiting_o = (MAX_NB_TRAN + 1)'(count_q);

endmodule

// File: tb/tb_udma_hyper_trans_sched.sv
// -----------------------------------------------------------------------------
// tb_udma_hyper_trans_sched
//
// Self-checking bench for udma_hyper_trans_sched (NB_CH=2, CFG_W=64,
// MAX_NB_TRAN=8): a cycle table for the single-request flow, hand-written
// sequences for fairness, the full boundary, push/pop at count 3, done
// handling and reset mid-flight, then random traffic against a queue model.
// -----------------------------------------------------------------------------
module tb_udma_hyper_trans_sched;

    localparam int NB_CH = 2;
    localparam int CFG_W = 64;
    localparam int MAX   = 8;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [NB_CH-1:0]       req_valid_i;
    logic [NB_CH*CFG_W-1:0] req_cfg_i;
    logic [NB_CH-1:0]       req_ready_o;
    logic                   trans_valid_o;
    logic [CFG_W-1:0]       trans_cfg_o;
    logic [0:0]             trans_id_o;
    logic                   trans_ready_i;
    logic                   trans_done_i;
    logic [MAX:0]           nb_trans_waiting_o;
    logic                   busy_o;

    udma_hyper_trans_sched #(
        .NB_CH       (NB_CH),
        .CFG_W       (CFG_W),
        .MAX_NB_TRAN (MAX)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_cfg_i          (req_cfg_i),
        .req_ready_o        (req_ready_o),
        .trans_valid_o      (trans_valid_o),
        .trans_cfg_o        (trans_cfg_o),
        .trans_id_o         (trans_id_o),
        .trans_ready_i      (trans_ready_i),
        .trans_done_i       (trans_done_i),
        .nb_trans_waiting_o (nb_trans_waiting_o),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the
    // falling edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni        = 1'b0;
        req_valid_i   = '0;
        req_cfg_i     = '0;
        trans_ready_i = 1'b0;
        trans_done_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic set_cfg(input logic [63:0] c0, input logic [63:0] c1);
        req_cfg_i = {c1, c0};
    endtask

    // Waits (bounded) for an offer, checks it, accepts it and completes it.
    task automatic drain_one(input string name, input logic exp_id, input logic [63:0] exp_cfg);
        int n = 0;
        trans_ready_i = 1'b0;
        trans_done_i  = 1'b0;
        sample();
        while (!trans_valid_o && n < 20) begin
            step();
            sample();
            n++;
        end
        check({name, "_valid"}, 64'(trans_valid_o), 64'd1);
        check({name, "_cfg"}, trans_cfg_o, exp_cfg);
        check({name, "_id"}, 64'(trans_id_o), 64'(exp_id));
        trans_ready_i = 1'b1;
        step();
        trans_ready_i = 1'b0;
        trans_done_i  = 1'b1;
        step();
        trans_done_i  = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [63:0] cfg1;
        logic        rdy;
        logic        done;
        logic [1:0]  e_ready;
        logic        e_tv;
        logic        e_id;
        logic [63:0] e_cfg;
        int          e_cnt;
        logic        e_busy;
    } vec_t;

    vec_t tbl [10];

    typedef struct packed {
        logic        id;
        logic [63:0] cfg;
    } ent_t;

    ent_t mq[$];
    int   m_last;
    bit   m_offer;
    bit   m_flight;

    function automatic int model_grant(input logic [1:0] v);
        if (mq.size() >= MAX) return -1;
        for (int k = 1; k <= NB_CH; k++) begin
            int id = (m_last + k) % NB_CH;
            if (v[id]) return id;
        end
        return -1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // valid  cfg1   rdy   done  e_ready e_tv  e_id  e_cfg  cnt e_busy
        tbl[0] = '{2'b10, 64'hA5, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 64'h0,  0, 1'b0};
        tbl[1] = '{2'b00, 64'hA5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 64'h0,  1, 1'b0};
        tbl[2] = '{2'b00, 64'h00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 64'hA5, 1, 1'b1};
        tbl[3] = '{2'b00, 64'h00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 64'hA5, 1, 1'b1};
        tbl[4] = '{2'b00, 64'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 64'h0,  0, 1'b1};
        tbl[5] = '{2'b00, 64'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 64'h0,  0, 1'b1};
        tbl[6] = '{2'b00, 64'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 64'h0,  0, 1'b0};
        tbl[7] = '{2'b00, 64'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 64'h0,  0, 1'b0};
        tbl[8] = '{2'b00, 64'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 64'h0,  0, 1'b0};
        tbl[9] = '{2'b00, 64'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 64'h0,  0, 1'b0};

        // ---------------- reset state, with requests driven ----------------
        rst_ni        = 1'b0;
        req_valid_i   = 2'b11;
        req_cfg_i     = '1;
        trans_ready_i = 1'b1;
        trans_done_i  = 1'b1;
        repeat (2) @(posedge clk_i);
        sample();
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_tvalid", 64'(trans_valid_o), 64'd0);
        check("rst_cfg", trans_cfg_o, 64'd0);
        check("rst_id", 64'(trans_id_o), 64'd0);
        check("rst_count", 64'(nb_trans_waiting_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);

        // ---------------- single request, table driven ---------------------
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req_valid_i   = tbl[i].valid;
            set_cfg(64'h0, tbl[i].cfg1);
            trans_ready_i = tbl[i].rdy;
            trans_done_i  = tbl[i].done;
            sample();
            check($sformatf("tbl%0d_ready", i), 64'(req_ready_o), 64'(tbl[i].e_ready));
            check($sformatf("tbl%0d_tvalid", i), 64'(trans_valid_o), 64'(tbl[i].e_tv));
            check($sformatf("tbl%0d_id", i), 64'(trans_id_o), 64'(tbl[i].e_id));
            check($sformatf("tbl%0d_cfg", i), trans_cfg_o, tbl[i].e_cfg);
            check($sformatf("tbl%0d_count", i), 64'(nb_trans_waiting_o), 64'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_busy", i), 64'(busy_o), 64'(tbl[i].e_busy));
            step();
        end
        trans_ready_i = 1'b0;
        trans_done_i  = 1'b0;

        // ---------------- fairness until full -------------------------------
        do_reset();
        req_valid_i = 2'b11;
        set_cfg(64'hC0, 64'hC1);
        for (int i = 0; i < MAX; i++) begin
            sample();
            check($sformatf("fair_grant%0d", i), 64'(req_ready_o), 64'(1 << (i % 2)));
            check($sformatf("fair_count%0d", i), 64'(nb_trans_waiting_o), 64'(i));
            step();
        end
        for (int i = 0; i < 3; i++) begin
            sample();
            check("full_no_grant", 64'(req_ready_o), 64'd0);
            check("full_count", 64'(nb_trans_waiting_o), 64'd8);
            step();
        end

        // ---------------- full boundary: pop and request together ----------
        trans_ready_i = 1'b1;
        sample();
        check("fullpop_no_grant", 64'(req_ready_o), 64'd0);
        check("fullpop_head_id", 64'(trans_id_o), 64'd0);
        check("fullpop_head_cfg", trans_cfg_o, 64'hC0);
        step();
        trans_ready_i = 1'b0;
        sample();
        check("fullpop_count7", 64'(nb_trans_waiting_o), 64'd7);
        check("fullpop_next_grant", 64'(req_ready_o), 64'b01);
        step();
        sample();
        check("fullpop_count8", 64'(nb_trans_waiting_o), 64'd8);
        check("fullpop_ready0", 64'(req_ready_o), 64'd0);
        check("fullpop_active_busy", 64'(busy_o), 64'd1);
        step();

        // ---------------- done in ACTIVE, then in ISSUE --------------------
        req_valid_i  = 2'b00;
        trans_done_i = 1'b1;
        step();
        trans_done_i = 1'b0;
        sample();
        check("done_active_busy", 64'(busy_o), 64'd0);
        step();
        sample();
        check("reissue_valid", 64'(trans_valid_o), 64'd1);
        trans_done_i = 1'b1;
        step();
        trans_done_i = 1'b0;
        sample();
        check("done_issue_valid", 64'(trans_valid_o), 64'd1);
        check("done_issue_busy", 64'(busy_o), 64'd1);
        check("done_issue_id", 64'(trans_id_o), 64'd1);
        step();

        // ---------------- simultaneous push and pop at count 3 -------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 2'b01;
            set_cfg(64'hA0 + 64'(i), 64'h0);
            step();
        end
        req_valid_i   = 2'b10;
        set_cfg(64'h0, 64'hB3);
        trans_ready_i = 1'b1;
        sample();
        check("pp_count_before", 64'(nb_trans_waiting_o), 64'd3);
        check("pp_grant", 64'(req_ready_o), 64'b10);
        check("pp_head_cfg", trans_cfg_o, 64'hA0);
        step();
        req_valid_i   = 2'b00;
        trans_ready_i = 1'b0;
        sample();
        check("pp_count_after", 64'(nb_trans_waiting_o), 64'd3);
        step();
        trans_done_i = 1'b1;
        step();
        trans_done_i = 1'b0;
        drain_one("pp_e1", 1'b0, 64'hA1);
        drain_one("pp_e2", 1'b0, 64'hA2);
        drain_one("pp_e3", 1'b1, 64'hB3);

        // ---------------- reset mid-flight ---------------------------------
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_valid_i = 2'b01;
            set_cfg(64'h10 + 64'(i), 64'h0);
            step();
        end
        req_valid_i   = 2'b00;
        trans_ready_i = 1'b1;
        sample();
        check("mid_offer", 64'(trans_valid_o), 64'd1);
        step();
        trans_ready_i = 1'b0;
        sample();
        check("mid_count5", 64'(nb_trans_waiting_o), 64'd5);
        check("mid_active", 64'(busy_o), 64'd1);
        rst_ni      = 1'b0;
        req_valid_i = 2'b11;
        #1;
        check("mid_rst_ready", 64'(req_ready_o), 64'd0);
        check("mid_rst_tvalid", 64'(trans_valid_o), 64'd0);
        check("mid_rst_cfg", trans_cfg_o, 64'd0);
        check("mid_rst_id", 64'(trans_id_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_count", 64'(nb_trans_waiting_o), 64'd0);
        step();
        rst_ni      = 1'b1;
        req_valid_i = 2'b00;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("post_rst_tvalid", 64'(trans_valid_o), 64'd0);
            check("post_rst_count", 64'(nb_trans_waiting_o), 64'd0);
            step();
        end

        // ---------------- random traffic against the queue model -----------
        do_reset();
        mq.delete();
        m_last   = NB_CH - 1;
        m_offer  = 1'b0;
        m_flight = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int   rate;
            int   g;
            int   start_size;
            ent_t e;
            rate = ((cyc / 250) % 2 == 0) ? 70 : 15;
            req_valid_i[0] = ($urandom_range(0, 99) < rate);
            req_valid_i[1] = ($urandom_range(0, 99) < rate);
            set_cfg({$urandom, $urandom}, {$urandom, $urandom});
            trans_ready_i  = ($urandom_range(0, 1) == 1);
            trans_done_i   = ($urandom_range(0, 2) == 0);
            sample();
            g = model_grant(req_valid_i);
            check("rnd_ready", 64'(req_ready_o), (g >= 0) ? 64'(1 << g) : 64'd0);
            check("rnd_tvalid", 64'(trans_valid_o), 64'(m_offer));
            check("rnd_cfg", trans_cfg_o, m_offer ? mq[0].cfg : 64'd0);
            check("rnd_id", 64'(trans_id_o), m_offer ? 64'(mq[0].id) : 64'd0);
            check("rnd_count", 64'(nb_trans_waiting_o), 64'(mq.size()));
            check("rnd_busy", 64'(busy_o), 64'(m_offer || m_flight));
            start_size = mq.size();
            if (m_offer && trans_ready_i) begin
                void'(mq.pop_front());
                m_offer  = 1'b0;
                m_flight = 1'b1;
            end else if (m_flight && trans_done_i) begin
                m_flight = 1'b0;
            end else if (!m_offer && !m_flight && start_size > 0) begin
                m_offer = 1'b1;
            end
            if (g >= 0) begin
                e.id  = 1'(g);
                e.cfg = req_cfg_i[g*CFG_W +: CFG_W];
                mq.push_back(e);
                m_last = g;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udma_hyper_trans_sched.md
UDMA_HYPER_TRANS_SCHED -- requirements
Module: udma_hyper_trans_sched

Interface
REQ-001 SHALL have parameter NB_CH, default 2: number of requesting register-interface instances (IDs).
REQ-002 SHALL have parameter CFG_W, default 64: width of one packed transaction descriptor.
REQ-003 SHALL have parameter MAX_NB_TRAN, default 8: queue depth in entries.
REQ-004 SHALL define IDW = max(1, $clog2(NB_CH)) and CW = $clog2(MAX_NB_TRAN)+1.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid_i, input, NB_CH: per-ID transaction request (trans_valid of each register interface).
REQ-008 SHALL have port req_cfg_i, input, NB_CH*CFG_W: per-ID descriptor; ID i occupies bits [i*CFG_W +: CFG_W].
REQ-009 SHALL have port req_ready_o, output, NB_CH: per-ID accept, at most one bit high per cycle.
REQ-010 SHALL have port trans_valid_o, output, 1: descriptor offered to the hyperbus engine.
REQ-011 SHALL have port trans_cfg_o, output, CFG_W: head-of-queue descriptor.
REQ-012 SHALL have port trans_id_o, output, IDW: requester ID of the head entry.
REQ-013 SHALL have port trans_ready_i, input, 1: engine accepts the offered descriptor.
REQ-014 SHALL have port trans_done_i, input, 1: one-cycle pulse, engine finished the active transaction.
REQ-015 SHALL have port nb_trans_waiting_o, output, MAX_NB_TRAN+1: queued-entry count, zero-extended from CW bits.
REQ-016 SHALL have port busy_o, output, 1: a transaction is being issued or is in flight.

Function
REQ-017 SHALL hold a FIFO of MAX_NB_TRAN entries {ID, descriptor}, with read/write pointers wrapping modulo MAX_NB_TRAN and a CW-bit count.
REQ-018 SHALL arbitrate round-robin: highest priority goes to ID (last_grant+1) mod NB_CH, and last_grant = NB_CH-1 after reset so ID 0 wins first.
REQ-019 SHALL grant one requester per cycle only when count < MAX_NB_TRAN at the start of the cycle; req_ready_o[g] is asserted combinationally in the same cycle, and the entry is written at that clock edge.
REQ-020 SHALL update last_grant only on an actual grant; when full, SHALL assert no req_ready_o bit and leave last_grant unchanged.
REQ-021 SHALL implement a sequencer FSM with states IDLE, ISSUE and ACTIVE.
REQ-022 SHALL transition IDLE->ISSUE when count > 0.
REQ-023 SHALL, in ISSUE, assert trans_valid_o=1 and drive trans_cfg_o/trans_id_o from the head entry, stable until accepted.
REQ-024 SHALL, in ISSUE with trans_ready_i=1, pop the head and transition ISSUE->ACTIVE.
REQ-025 SHALL transition ACTIVE->IDLE on trans_done_i=1.
REQ-026 SHALL ignore trans_done_i outside ACTIVE and trans_ready_i outside ISSUE.
REQ-027 SHALL drive trans_valid_o=0 and trans_cfg_o/trans_id_o=0 outside ISSUE.
REQ-028 SHALL assert busy_o = (state != IDLE).
REQ-029 SHALL leave count unchanged on a simultaneous push and pop; push alone +1; pop alone -1.
REQ-030 SHALL deliver a descriptor granted in cycle N to an empty, idle block with trans_valid_o=1 in cycle N+2.
REQ-031 SHALL allow at most one transaction in flight; the next ISSUE occurs no earlier than the cycle after trans_done_i.
REQ-032 SHALL reflect the registered count on nb_trans_waiting_o, excluding the active transaction.

Reset
REQ-033 SHALL, while rst_ni=0, force state=IDLE, pointers=0, count=0, last_grant=NB_CH-1, trans_valid_o=0, trans_cfg_o=0, trans_id_o=0, busy_o=0, nb_trans_waiting_o=0, and req_ready_o=0.
REQ-034 SHALL, on reset asserted mid-operation (any state, any count), discard all queued and in-flight entries with no output glitch after deassertion.

Verification
REQ-035 SHALL cover single request: ID1 pulses req_valid_i with cfg 0xA5 in cycle 0 -> req_ready_o=2'b10 in cycle 0, trans_valid_o=1, trans_id_o=1, trans_cfg_o=0xA5 in cycle 2, count=1 at cycles 1-2.
REQ-036 SHALL cover fairness: both IDs continuously requesting with the engine stalled -> grant order 0,1,0,1,... until count=8, then req_ready_o=0.
REQ-037 SHALL cover full boundary: count=8 with a pop in the same cycle as a request -> no grant that cycle, grant next cycle, count returns to 8.
REQ-038 SHALL cover simultaneous push and pop at count=3 -> count stays 3 and FIFO order is preserved.
REQ-039 SHALL cover done handling: trans_done_i pulsed in IDLE or ISSUE -> no state change; in ACTIVE -> busy_o=0 the next cycle.
REQ-040 SHALL cover reset mid-flight: rst_ni low in ACTIVE with count=5 -> all outputs 0 immediately, and after release no trans_valid_o without a new request.
